// File: rtl/awgn_scale_serializer.sv
// rtl/awgn_scale_serializer.sv - Box-Muller scale stage: x0=f*g0, x1=f*g1, round/saturate, serialize
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready input handshake for f (UQ4.13), g0/g1 (signed Q1.15)
//   out_valid/out_ready output handshake for x (signed Q5.11)
//   out_sel           0: x carries x0, 1: x carries x1
//   pair_cnt          completed pairs, wraps modulo 2^CW
module awgn_scale_serializer #(
    parameter int FW    = 17,
    parameter int GW    = 16,
    parameter int OW    = 16,
    parameter int SHIFT = 17,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FW-1:0] f,
    input  logic [GW-1:0] g0,
    input  logic [GW-1:0] g1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] x,
    output logic          out_sel,
    output logic [CW-1:0] pair_cnt
);

    localparam int PW = FW + GW + 1;        // full product width
    localparam int RW = PW + 1 - SHIFT;     // width after rounding add and shift

    localparam logic [PW:0]             HALF    = (PW+1)'(1) << (SHIFT - 1);
    localparam logic signed [RW-1:0]    SAT_MAX = RW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [RW-1:0]    SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_EMPTY, S_HAVE0, S_HAVE1} state_t;

    // Round half toward +inf, then clamp into the output range.
    function automatic logic [OW-1:0] rnd_sat(input logic [FW-1:0] fv, input logic [GW-1:0] gv);
        logic signed [PW-1:0] p;
        logic        [PW:0]   s;
        logic signed [RW-1:0] r;
        logic        [OW-1:0] res;
        p = PW'($signed({1'b0, fv})) * PW'($signed(gv));
        s = {p[PW-1], p} + HALF;
        r = $signed(s[PW:SHIFT]);           // upper bits == arithmetic shift by SHIFT
        if (RW > OW) begin
            if (r > SAT_MAX)
                res = OW'(SAT_MAX);
            else if (r < SAT_MIN)
                res = OW'(SAT_MIN);
            else
                res = OW'(r);
        end else begin
            res = OW'(r);
        end
        return res;
    endfunction

    logic [FW-1:0] f_r;
    logic [GW-1:0] g0_r, g1_r;
    logic          v1;
    logic [OW-1:0] xr0, xr1;
    state_t        state, state_nxt;
    logic          s2_load;

    assign s2_load  = v1 && (state == S_EMPTY || (state == S_HAVE1 && out_ready));
    assign in_ready = !v1 || s2_load;

    // Stage 1: input holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            f_r  <= '0;
            g0_r <= '0;
            g1_r <= '0;
        end else begin
            if (in_valid && in_ready) begin
                v1   <= 1'b1;
                f_r  <= f;
                g0_r <= g0;
                g1_r <= g1;
            end else if (s2_load) begin
                v1 <= 1'b0;
            end
        end
    end

    // Stage 2: pair register, state register and pair counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_EMPTY;
            xr0      <= '0;
            xr1      <= '0;
            pair_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (s2_load) begin
                xr0 <= rnd_sat(f_r, g0_r);
                xr1 <= rnd_sat(f_r, g1_r);
            end
            if (state == S_HAVE1 && out_ready)
                pair_cnt <= pair_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (s2_load)   state_nxt = S_HAVE0;
            S_HAVE0: if (out_ready) state_nxt = S_HAVE1;
            // Completing x1 while a new pair loads hands off straight to x0 with no gap.
            S_HAVE1: if (out_ready) state_nxt = s2_load ? S_HAVE0 : S_EMPTY;
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state != S_EMPTY);
        out_sel   = (state == S_HAVE1);
        x         = (state == S_HAVE1) ? xr1 : xr0;
    end

endmodule

// File: tb/tb_awgn_scale_serializer.sv
// tb/tb_awgn_scale_serializer.sv - scoreboard bench for awgn_scale_serializer
module tb_awgn_scale_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] f;
    logic [15:0] g0, g1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x;
    logic        out_sel;
    logic [15:0] pair_cnt;

    awgn_scale_serializer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .f(f), .g0(g0), .g1(g1),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .out_sel(out_sel), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic        sel;
    } beat_t;

    beat_t sbq[$];
    int    acc_cyc[$];
    int    beat_cyc[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    pairs_exp = 0;
    int    rdy_mode = 0;     // 0: manual, 1: always ready, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: real-valued product f*g scaled into Q5.11, rounded half up, clamped.
    function automatic logic [15:0] ref_x(input logic [16:0] fv, input logic [15:0] gv);
        longint fi, gi, p, q;
        logic [15:0] r;
        fi = longint'(fv);
        gi = longint'($signed(gv));
        p  = fi * gi + 65536;            // product in 2^-28 units, plus half an output LSB
        if (p >= 0) q = p / 131072;
        else        q = -((-p + 131071) / 131072);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        r = q[15:0];
        return r;
    endfunction

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1)      out_ready = 1'b1;
            else if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: sampled at negedge, predicts transfers at the following rising edge.
    logic        hold = 1'b0;
    logic [15:0] hx;
    logic        hs;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_x", x, hx);
                check("hold_sel", out_sel, hs);
            end
            check("pair_cnt", pair_cnt, pairs_exp % 65536);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: x=0x%0h sel=%0d", x, out_sel);
                end else begin
                    e = sbq.pop_front();
                    check("beat_x", x, e.x);
                    check("beat_sel", out_sel, e.sel);
                    if (e.sel) pairs_exp++;
                end
                beat_cyc.push_back(cyc);
            end
            hold = out_valid && !out_ready;
            hx   = x;
            hs   = out_sel;
        end
    end

    task automatic send(input logic [16:0] fv, input logic [15:0] g0v, input logic [15:0] g1v,
                        input logic [15:0] e0, input logic [15:0] e1);
        bit done;
        done = 0;
        in_valid = 1'b1;
        f  = fv;
        g0 = g0v;
        g1 = g1v;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                sbq.push_back('{e0, 1'b0});
                sbq.push_back('{e1, 1'b1});
                acc_cyc.push_back(cyc);
                done = 1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready never rose for f=0x%0h", fv);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        logic [16:0] fv;
        logic [15:0] a, b;
        fv = 17'($urandom_range(0, 131071));
        if ($urandom_range(0, 7) == 0) fv = 17'h1FFFF;
        a = 16'($urandom);
        b = 16'($urandom);
        send(fv, a, b, ref_x(fv, a), ref_x(fv, b));
    endtask

    task automatic drain();
        bit done;
        done = 0;
        in_valid = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            if (sbq.size() == 0) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d beats outstanding", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        sbq.delete();
        pairs_exp = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        f = '0;
        g0 = '0;
        g1 = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_pair_cnt", pair_cnt, 0);
        check("rst_x", x, 0);
        check("rst_out_sel", out_sel, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic pair with latency check
        rdy_mode = 1;
        send(17'h02000, 16'h4000, 16'hC000, 16'h0400, 16'hFC00);
        in_valid = 1'b0;
        check("lat_not_yet", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid", out_valid, 1);
        check("lat_x0", x, 16'h0400);
        check("lat_sel", out_sel, 0);
        drain();
        check("basic_pair_cnt", pair_cnt, 1);

        // Rounding and extremes
        send(17'h00004, 16'h4000, 16'hC000, 16'h0001, 16'h0000);
        send(17'h1FFFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
        drain();

        // Streaming: 8 back-to-back inputs
        do_reset();
        rdy_mode = 1;
        acc_cyc.delete();
        beat_cyc.delete();
        for (int i = 0; i < 8; i++) send_rand();
        drain();
        for (int i = 2; i < 8; i++) check("stream_acc_gap", acc_cyc[i] - acc_cyc[i-1], 2);
        check("stream_beats", beat_cyc.size(), 16);
        if (beat_cyc.size() == 16) check("stream_contig", beat_cyc[15] - beat_cyc[0], 15);
        check("stream_pair_cnt", pair_cnt, 8);

        // Backpressure
        rdy_mode = 0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(17'h03000, 16'h2000, 16'hE000, ref_x(17'h03000, 16'h2000), ref_x(17'h03000, 16'hE000));
        send(17'h0ABCD, 16'h1234, 16'h8765, ref_x(17'h0ABCD, 16'h1234), ref_x(17'h0ABCD, 16'h8765));
        in_valid = 1'b1;
        f = 17'h12345;
        g0 = 16'h7000;
        g1 = 16'h9000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        out_ready = 1'b1;
        send(17'h12345, 16'h7000, 16'h9000, ref_x(17'h12345, 16'h7000), ref_x(17'h12345, 16'h9000));
        drain();

        // Reset mid-pair while x1 is presented
        rdy_mode = 0;
        out_ready = 1'b0;
        send(17'h05555, 16'h3333, 16'hCCCC, ref_x(17'h05555, 16'h3333), ref_x(17'h05555, 16'hCCCC));
        in_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("mid_x0_seen", seen, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("mid_have1_sel", out_sel, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_pair_cnt", pair_cnt, 0);
        check("mid_rst_in_ready", in_ready, 1);
        sbq.delete();
        pairs_exp = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        rdy_mode = 1;
        send(17'h04000, 16'h1000, 16'hF000, ref_x(17'h04000, 16'h1000), ref_x(17'h04000, 16'hF000));
        drain();
        check("mid_after_pair_cnt", pair_cnt, 1);

        // Randomized traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            send_rand();
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        check("rand_queue_empty", sbq.size(), 0);

        rdy_mode = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
